// File: rtl/wb_trace_fifo_pkg.sv
// Shared definitions for the write-back trace FIFO: bus widths, default sizing
// and the trace entry layout used by the RTL, the bench and any future dumper.
package wb_trace_fifo_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TRACE_DEPTH = 16;
  localparam int unsigned TRACE_SEQ_W = 16;
  localparam int unsigned TRACE_OVF_W = 8;

  // One captured register write at the default sequence-tag width
  typedef struct packed {
    logic [TRACE_SEQ_W-1:0] seq;
    logic [REG_ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]      data;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_fifo_if.sv
// Trace FIFO bus: write-back capture side plus the valid/ready drain port.
//  master: drives wb_*_TRACE, capture_en, out_ready; observes out_*, count, overflow_cnt
//  slave : the FIFO itself (opposite directions)
interface wb_trace_fifo_if
  import wb_trace_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = TRACE_DEPTH,
  parameter int unsigned SEQ_W = TRACE_SEQ_W,
  parameter int unsigned OVF_W = TRACE_OVF_W
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  wb_en_TRACE;
  logic [REG_ADDR_W-1:0] wb_addr_TRACE;
  logic [DATA_W-1:0]     wb_data_TRACE;
  logic                  capture_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [SEQ_W-1:0]      out_seq;
  logic [REG_ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0]     out_data;
  logic [CNT_W-1:0]      count;
  logic [OVF_W-1:0]      overflow_cnt;

  modport master (
    output wb_en_TRACE, wb_addr_TRACE, wb_data_TRACE, capture_en, out_ready,
    input  out_valid, out_seq, out_addr, out_data, count, overflow_cnt
  );

  modport slave (
    input  wb_en_TRACE, wb_addr_TRACE, wb_data_TRACE, capture_en, out_ready,
    output out_valid, out_seq, out_addr, out_data, count, overflow_cnt
  );

endinterface

// File: rtl/wb_trace_fifo_sync_fifo_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
//  clk, we/waddr/wdata (write), raddr/rdata (combinational read). No reset: contents
//  are don't-care until written.
module sync_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 53
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Write-back trace FIFO: captures committed register writes (excluding $zero),
// tags each with a sequence number, and drains them show-ahead over valid/ready.
// Drops on full are counted in a saturating overflow counter; the sequence tag
// still advances so gaps in out_seq expose lost writes.
//  clk_TRACE, rst_n_TRACE (async active-low), bus (wb_trace_fifo_if.slave)
module wb_trace_fifo
  import wb_trace_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = TRACE_DEPTH,
  parameter int unsigned SEQ_W = TRACE_SEQ_W,
  parameter int unsigned OVF_W = TRACE_OVF_W
) (
  input  logic           clk_TRACE,
  input  logic           rst_n_TRACE,
  wb_trace_fifo_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [SEQ_W-1:0]      seq;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  entry_t           out_q, out_d;

  logic   push, pop, full, store, drop;
  entry_t new_entry;
  logic [ENTRY_W-1:0] rd_data;

  // Next-state logic for pointers, occupancy, tagging and the registered head
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    seq_d       = seq_q;
    ovf_d       = ovf_q;
    out_d       = out_q;

    push  = bus.wb_en_TRACE & bus.capture_en & (bus.wb_addr_TRACE != '0);
    pop   = out_valid_q & bus.out_ready;
    full  = (count_q == CNT_W'(DEPTH));
    store = push & (~full | pop);
    drop  = push & full & ~pop;

    new_entry.seq  = seq_q;
    new_entry.addr = bus.wb_addr_TRACE;
    new_entry.data = bus.wb_data_TRACE;

    if (store) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({store, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push) seq_d = seq_q + SEQ_W'(1);
    if (drop && (ovf_q != '1)) ovf_d = ovf_q + OVF_W'(1);

    out_valid_d = (count_d != '0);

    // Next head is the incoming entry when nothing older remains after this
    // cycle's pop; otherwise it is the stored entry at the advanced read pointer.
    if (store && (count_q == CNT_W'(pop))) begin
      out_d = new_entry;
    end else if (pop && (count_d != '0)) begin
      out_d = entry_t'(rd_data);
    end
  end

  // State registers; entries vanish and out_valid drops as soon as reset asserts
  always_ff @(posedge clk_TRACE or negedge rst_n_TRACE) begin
    if (!rst_n_TRACE) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      seq_q       <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      seq_q       <= seq_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_mem (
    .clk   (clk_TRACE),
    .we    (store),
    .waddr (wr_ptr_q),
    .wdata (ENTRY_W'(new_entry)),
    .raddr (rd_ptr_d),
    .rdata (rd_data)
  );

  assign bus.out_valid    = out_valid_q;
  assign bus.out_seq      = out_q.seq;
  assign bus.out_addr     = out_q.addr;
  assign bus.out_data     = out_q.data;
  assign bus.count        = count_q;
  assign bus.overflow_cnt = ovf_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: a vector table for single-cycle behaviour
// plus hand-written sequences for overflow, full push+pop, wrap/freeze and reset.
module tb_wb_trace_fifo;
  import wb_trace_fifo_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  wb_trace_fifo_if #(.DEPTH(DEPTH), .SEQ_W(TRACE_SEQ_W), .OVF_W(TRACE_OVF_W)) bus ();

  wb_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(TRACE_SEQ_W), .OVF_W(TRACE_OVF_W)) dut (
    .clk_TRACE   (clk),
    .rst_n_TRACE (rst_n),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [4:0]   addr;
    logic [31:0]  data;
    logic         cap;
    logic         rdy;
    logic         exp_valid;
    trace_entry_t exp_head;
    int           exp_count;
    int           exp_ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic en, input logic [4:0] a, input logic [31:0] d,
                     input logic cap, input logic rdy);
    bus.wb_en_TRACE   = en;
    bus.wb_addr_TRACE = a;
    bus.wb_data_TRACE = d;
    bus.capture_en    = cap;
    bus.out_ready     = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic chk_head(input string name, input int seq, input int addr, input int data);
    chk({name, "_valid"}, 64'(bus.out_valid), 64'(1));
    chk({name, "_seq"},   64'(bus.out_seq),   64'(seq));
    chk({name, "_addr"},  64'(bus.out_addr),  64'(addr));
    chk({name, "_data"},  64'(bus.out_data),  64'(data));
  endtask

  function automatic vec_t mk(input logic en, input logic [4:0] a, input logic [31:0] d,
                              input logic cap, input logic rdy, input logic ev,
                              input int es, input int ea, input int ed,
                              input int ec, input int eo);
    vec_t v;
    v.en = en; v.addr = a; v.data = d; v.cap = cap; v.rdy = rdy;
    v.exp_valid     = ev;
    v.exp_head.seq  = TRACE_SEQ_W'(es);
    v.exp_head.addr = REG_ADDR_W'(ea);
    v.exp_head.data = DATA_W'(ed);
    v.exp_count = ec;
    v.exp_ovf   = eo;
    return v;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    drv(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);

    //            en  addr  data          cap rdy  val seq addr data          cnt ovf
    vecs[0] = mk(1, 5'd8, 32'hDEAD_BEEF, 1, 0,   1,  0,  8, 32'hDEAD_BEEF,  1,  0);
    vecs[1] = mk(0, 5'd0, 32'd0,         1, 0,   1,  0,  8, 32'hDEAD_BEEF,  1,  0);
    vecs[2] = mk(0, 5'd0, 32'd0,         1, 1,   0,  0,  8, 32'hDEAD_BEEF,  0,  0);
    vecs[3] = mk(1, 5'd0, 32'h1234,      1, 0,   0,  0,  8, 32'hDEAD_BEEF,  0,  0);
    vecs[4] = mk(1, 5'd3, 32'd7,         1, 0,   1,  1,  3, 7,              1,  0);
    vecs[5] = mk(1, 5'd4, 32'd9,         1, 1,   1,  2,  4, 9,              1,  0);
    vecs[6] = mk(1, 5'd5, 32'd10,        0, 0,   1,  2,  4, 9,              1,  0);
    vecs[7] = mk(1, 5'd6, 32'd11,        1, 0,   1,  2,  4, 9,              2,  0);
    vecs[8] = mk(0, 5'd0, 32'd0,         1, 1,   1,  3,  6, 11,             1,  0);
    vecs[9] = mk(0, 5'd0, 32'd0,         1, 1,   0,  3,  6, 11,             0,  0);

    do_reset();
    chk("rst_valid", 64'(bus.out_valid),    64'(0));
    chk("rst_count", 64'(bus.count),        64'(0));
    chk("rst_ovf",   64'(bus.overflow_cnt), 64'(0));
    chk("rst_seq",   64'(bus.out_seq),      64'(0));
    chk("rst_data",  64'(bus.out_data),     64'(0));

    // Table-driven single-cycle vectors
    foreach (vecs[i]) begin
      drv(vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].cap, vecs[i].rdy);
      step();
      chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid),    64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_seq", i),   64'(bus.out_seq),      64'(vecs[i].exp_head.seq));
      chk($sformatf("vec%0d_addr", i),  64'(bus.out_addr),     64'(vecs[i].exp_head.addr));
      chk($sformatf("vec%0d_data", i),  64'(bus.out_data),     64'(vecs[i].exp_head.data));
      chk($sformatf("vec%0d_count", i), 64'(bus.count),        64'(vecs[i].exp_count));
      chk($sformatf("vec%0d_ovf", i),   64'(bus.overflow_cnt), 64'(vecs[i].exp_ovf));
    end

    // Overflow: 20 writes into a 16-deep FIFO with no drain
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 5'd1, 32'(i), 1'b1, 1'b0);
      step();
    end
    drv(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("ovf_count", 64'(bus.count),        64'(16));
    chk("ovf_cnt",   64'(bus.overflow_cnt), 64'(4));
    for (int i = 0; i < 16; i++) begin
      chk_head($sformatf("ovf_drain%0d", i), i, 1, i);
      drv(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
      step();
    end
    chk("ovf_empty", 64'(bus.count), 64'(0));
    chk("ovf_empty_valid", 64'(bus.out_valid), 64'(0));
    drv(1'b1, 5'd1, 32'd77, 1'b1, 1'b0);
    step();
    chk_head("ovf_next", 20, 1, 77);

    // Full push+pop: both accepted, no drop
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 5'd2, 32'(i), 1'b1, 1'b0);
      step();
    end
    drv(1'b1, 5'd2, 32'd99, 1'b1, 1'b1);
    step();
    chk("fpp_count", 64'(bus.count),        64'(16));
    chk("fpp_ovf",   64'(bus.overflow_cnt), 64'(0));
    chk_head("fpp_head", 1, 2, 1);
    for (int k = 0; k < 16; k++) begin
      chk_head($sformatf("fpp_drain%0d", k), k + 1, 2, (k < 15) ? k + 1 : 99);
      drv(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
      step();
    end
    chk("fpp_empty", 64'(bus.count), 64'(0));

    // Wrap: 40 write/drain pairs, then freeze capture
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drv(1'b1, 5'd2, 32'(1000 + i), 1'b1, 1'b0);
      step();
      chk_head($sformatf("wrap%0d", i), i, 2, 1000 + i);
      drv(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
      step();
      chk($sformatf("wrap%0d_count", i), 64'(bus.count), 64'(0));
    end
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 5'd2, 32'd5, 1'b0, 1'b0);
      step();
    end
    chk("frz_count", 64'(bus.count),     64'(0));
    chk("frz_valid", 64'(bus.out_valid), 64'(0));
    drv(1'b1, 5'd2, 32'd6, 1'b1, 1'b0);
    step();
    chk_head("frz_resume", 40, 2, 6);

    // Saturation, then asynchronous reset in the middle of a cycle
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drv(1'b1, 5'd9, 32'(i), 1'b1, 1'b0);
      step();
    end
    chk("sat_ovf",   64'(bus.overflow_cnt), 64'(255));
    chk("sat_count", 64'(bus.count),        64'(16));
    drv(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.out_valid),    64'(0));
    chk("arst_count", 64'(bus.count),        64'(0));
    chk("arst_ovf",   64'(bus.overflow_cnt), 64'(0));
    chk("arst_seq",   64'(bus.out_seq),      64'(0));
    step();
    rst_n = 1'b1;
    step();
    drv(1'b1, 5'd3, 32'd42, 1'b1, 1'b0);
    step();
    chk_head("arst_after", 0, 3, 42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
